// File: rtl/gpio_debounce_pkg.sv
// Shared defaults for the GPIO debouncer and a helper that validates the
// counter sizing so a too-narrow counter is caught before it can wrap.
package gpio_debounce_pkg;

  localparam int unsigned DEF_WIDTH         = 12;
  localparam int unsigned DEF_CNT_W         = 16;
  localparam int unsigned DEF_STABLE_CYCLES = 50000;

  // True when 1 <= stable < 2**cnt_w, i.e. the terminal count fits the counter.
  function automatic bit stable_cycles_ok(input int unsigned stable,
                                          input int unsigned cnt_w);
    return (stable >= 1) && ((cnt_w >= 32) || (stable < (32'd1 << cnt_w)));
  endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// One debounced input: two-flop synchronizer, stability counter, accepted
// level and registered rise/fall pulses aligned with the new level.
module gpio_debounce_bit
  import gpio_debounce_pkg::*;
#(
  parameter int unsigned CNT_W         = DEF_CNT_W,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  if (!stable_cycles_ok(STABLE_CYCLES, CNT_W)) begin : g_bad_cfg
    $error("gpio_debounce_bit: STABLE_CYCLES must satisfy 1 <= STABLE_CYCLES < 2**CNT_W");
  end

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;
  logic             toggle;

  // Bring the asynchronous raw level into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Accept the new value on the STABLE_CYCLES-th consecutive mismatch.
  always_comb begin
    toggle = (sync2 != level) && (cnt == LAST);
  end

  // Count consecutive mismatches; any agreement restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync2 == level) begin
      cnt <= '0;
    end else if (toggle) begin
      cnt   <= '0;
      level <= ~level;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Edge pulses use the pre-toggle level so they land with the new level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= toggle & ~level;
      fall <= toggle & level;
    end
  end

endmodule

// File: rtl/gpio_debounce.sv
// Debouncer bank for the board switches/buttons: WIDTH independent
// gpio_debounce_bit instances plus an optional sticky rising-event bank.
// Optional feature: define GPIO_DEBOUNCE_EVT_EN to enable evt_o/evt_clr_i;
// otherwise evt_o is tied to zero and evt_clr_i is ignored.
module gpio_debounce
  import gpio_debounce_pkg::*;
#(
  parameter int unsigned WIDTH         = DEF_WIDTH,
  parameter int unsigned CNT_W         = DEF_CNT_W,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] level_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic [WIDTH-1:0] evt_o,
  input  logic [WIDTH-1:0] evt_clr_i
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gpio_debounce_bit #(
      .CNT_W        (CNT_W),
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_bit (
      .clk  (clk_i),
      .rst_n(arst_n_i),
      .raw  (raw_i[i]),
      .level(level_o[i]),
      .rise (rise_o[i]),
      .fall (fall_o[i])
    );
  end

`ifdef GPIO_DEBOUNCE_EVT_EN
  // Sticky rise flags; a coincident set wins over write-1-to-clear.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      evt_o <= '0;
    end else begin
      evt_o <= (evt_o & ~evt_clr_i) | rise_o;
    end
  end
`else
  logic unused_evt_clr;

  // Event bank disabled: no state, clear strobe deliberately unused.
  always_comb begin
    evt_o           = '0;
    unused_evt_clr  = ^evt_clr_i;
  end
`endif

endmodule
